biriscv_issue_sched: RTL and testbench
======================================

Name: biriscv_issue_sched

Overview:
- In-order dual-issue scheduler between the decode-stage fetch FIFO and the two execution pipes.
- Consumes the two decoded FIFO head slots and their class bits, and drives the per-slot accept/pop strobes.
- Applies RAW/WAW hazard checks against an internal register scoreboard, pairing rules and CSR serialisation.
- Registers accepted instructions into two issue registers feeding pipe0/pipe1.

Parameters:
DUAL_ISSUE, 1, 0 forces single issue (slot1 only issues when slot0 is empty)
POST_SERIAL_CYCLES, 2, cycles held single-issue after a serialised instruction (1..7)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous reset, active-low
slot0_valid_i  in  1  FIFO slot0 valid
slot0_instr_i  in  32  slot0 opcode
slot0_pc_i  in  32  slot0 PC
slot0_class_i  in  8  {invalid,exec,lsu,branch,mul,div,csr,rd_valid}
slot1_valid_i  in  1  FIFO slot1 valid
slot1_instr_i  in  32  slot1 opcode
slot1_pc_i  in  32  slot1 PC
slot1_class_i  in  8  as slot0
slot0_accept_o  out  1  pop slot0
slot1_accept_o  out  1  pop slot1
stall_i  in  1  execution stall; hold issue registers
branch_request_i  in  1  pipeline flush
pipe_idle_i  in  1  no instruction in execute/mem/wb
wb_load_valid_i  in  1  load writeback
wb_load_rd_i  in  5  load writeback register
div_complete_i  in  1  divider result written back
issue0_valid_o  out  1  pipe0 issue valid
issue0_instr_o  out  32  pipe0 opcode
issue0_pc_o  out  32  pipe0 PC
issue1_valid_o  out  1  pipe1 issue valid
issue1_instr_o  out  32  pipe1 opcode
issue1_pc_o  out  32  pipe1 PC

Behaviour:
- Fields: rd=[11:7], rs1=[19:15], rs2=[24:20]. Hazard sources are always rs1/rs2; the rd check applies only when rd_valid is set. x0 is never marked pending or hazarded.
- Reset (rst_ni=0 at a clk edge): all outputs 0, scoreboard 0, div_busy 0, FSM=RUN, post counter 0.
- Priority each cycle: reset > branch_request_i > stall_i > normal.
- branch_request_i:
  - accepts 0 that cycle; both issue valids 0 next cycle.
  - FSM->RUN, post counter 0.
  - Scoreboard and div_busy retained, because in-flight loads/div still write back.
- stall_i: accepts 0; issue registers hold their values.
- Issue latency: accept at cycle N gives issue*_valid_o=1 with that instruction at cycle N+1. An unaccepted cycle loads valid 0.
- slot0 eligible when all hold:
  - valid
  - FSM in RUN or POST
  - no source/dest bit set in the scoreboard
  - not (div && div_busy)
  - not (csr || invalid)
- slot0 head with csr or invalid: FSM RUN->DRAIN with no accepts. In DRAIN, when pipe_idle_i && scoreboard==0 && !div_busy && both issue valids 0, slot0 issues alone and FSM->POST with counter=POST_SERIAL_CYCLES.
- POST: single issue only. Counter decrements per cycle; at 0 the FSM returns to RUN.
- slot1 eligible only if (slot0 accepted this cycle, or slot0_valid_i=0), plus its own scoreboard/div checks. When paired with slot0, all of the following must also hold:
  - DUAL_ISSUE=1 and FSM=RUN
  - slot0 not branch
  - slot1 rs1/rs2/rd does not match slot0 rd (when slot0 rd_valid)
  - not both lsu, not both mul, not both div
  - slot1 not csr/invalid
- slot1 csr/invalid with slot0 empty: handled by the DRAIN path exactly as slot0, issued on pipe1.
- Scoreboard:
  - An issued load (lsu && rd_valid) sets pending[rd].
  - An issued div sets pending[rd], sets div_busy and captures div_rd_q.
  - wb_load_valid_i clears pending[wb_load_rd_i].
  - div_complete_i clears pending[div_rd_q] and div_busy.
  - Set and clear of the same rd in one cycle: set wins.
  - wb_load_rd_i=0 is ignored.
- Ordering: slot1 never issues without slot0 being empty or issued in the same cycle.

Optional Feature:
BIRISCV_ISSUE_STATS_EN
- Defined: adds three 32-bit wrapping counters as outputs (stat_dual_o, stat_single_o, stat_stall_o).
  - stat_dual_o counts cycles with both accepts.
  - stat_single_o counts cycles with exactly one accept.
  - stat_stall_o counts cycles with some slot valid but no accept.
  - Counters are cleared by reset only.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package biriscv_issue_pkg: class-bit index constants (CLS_INVALID..CLS_RD_VALID), FSM state encoding (RUN, DRAIN, POST), and rd/rs field bit positions.
- One sub-module: biriscv_issue_scoreboard, holding the 32-bit pending vector, div_busy/div_rd_q and the set/clear logic, with a combinational hazard query for two slots.

Test Plan:
- Independent ALU pair (add x1; add x2) -> both accepts 1 same cycle; issue0/issue1 valid next cycle with matching PCs.
- slot0 add x5, slot1 sub x6,x5 -> slot0 accepted alone; slot1 accepted next cycle; issue1 carries sub one cycle after add.
- Load x7; next add x8,x7 -> add blocked until wb_load_valid_i with rd=7, accepted the same cycle as the writeback. Then set+clear x7 in one cycle -> x7 stays pending.
- CSR at slot0 while pipe_idle_i=0 -> no accepts until pipe_idle_i=1; CSR issues alone; next 2 cycles show no dual issue; then dual issue resumes.
- branch_request_i during DRAIN with stall_i=1 -> accepts 0; issue valids 0 next cycle; FSM RUN; pending load bit still set.
- Div issued then second div -> second blocked until div_complete_i; rst_ni low mid-div clears div_busy and the scoreboard.

Source files
------------

// File: rtl/biriscv_issue_pkg.sv
`default_nettype none
// biriscv_issue_pkg: class-bit indices, instruction field positions and the
// scheduler FSM encoding shared by the issue scheduler and its scoreboard.
package biriscv_issue_pkg;

  localparam int CLS_RD_VALID = 0;
  localparam int CLS_CSR      = 1;
  localparam int CLS_DIV      = 2;
  localparam int CLS_MUL      = 3;
  localparam int CLS_BRANCH   = 4;
  localparam int CLS_LSU      = 5;
  localparam int CLS_EXEC     = 6;
  localparam int CLS_INVALID  = 7;

  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd0;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd1;
  localparam logic [STATE_W-1:0] ST_POST  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/biriscv_issue_scoreboard.sv
`default_nettype none
// biriscv_issue_scoreboard: pending-writeback register vector plus divider
// busy tracking, with a same-cycle hazard query for both FIFO head slots.
module biriscv_issue_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] s0_rs1,
  input  logic [4:0] s0_rs2,
  input  logic [4:0] s0_rd,
  input  logic       s0_rd_valid,
  input  logic       s0_div,
  input  logic [4:0] s1_rs1,
  input  logic [4:0] s1_rs2,
  input  logic [4:0] s1_rd,
  input  logic       s1_rd_valid,
  input  logic       s1_div,
  input  logic       set0_load,
  input  logic       set0_div,
  input  logic       set1_load,
  input  logic       set1_div,
  input  logic       wb_load_valid,
  input  logic [4:0] wb_load_rd,
  input  logic       div_complete,
  output logic       hazard0,
  output logic       hazard1,
  output logic       idle
);

  logic [31:0] pending;
  logic        div_busy;
  logic [4:0]  div_rd_q;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] pending_eff;
  logic        busy_eff;

  always_comb begin
    clr_mask = '0;
    if (wb_load_valid && (wb_load_rd != 5'd0)) clr_mask[wb_load_rd] = 1'b1;
    if (div_complete) clr_mask[div_rd_q] = 1'b1;
    set_mask = '0;
    if (set0_load || set0_div) set_mask[s0_rd] = 1'b1;
    if (set1_load || set1_div) set_mask[s1_rd] = 1'b1;
    set_mask[0] = 1'b0;
  end

  // Writebacks landing this cycle release their consumers in the same cycle.
  assign pending_eff = pending & ~clr_mask;
  assign busy_eff    = div_busy & ~div_complete;

  assign hazard0 = pending_eff[s0_rs1] | pending_eff[s0_rs2] |
                   (s0_rd_valid & pending_eff[s0_rd]) | (s0_div & busy_eff);
  assign hazard1 = pending_eff[s1_rs1] | pending_eff[s1_rs2] |
                   (s1_rd_valid & pending_eff[s1_rd]) | (s1_div & busy_eff);
  assign idle    = (pending_eff == '0) && !busy_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      div_busy <= 1'b0;
      div_rd_q <= '0;
    end else begin
      pending  <= pending_eff | set_mask;
      div_busy <= busy_eff | set0_div | set1_div;
      if (set0_div)      div_rd_q <= s0_rd;
      else if (set1_div) div_rd_q <= s1_rd;
    end
  end

endmodule
`default_nettype wire

// File: rtl/biriscv_issue_sched.sv
`default_nettype none
// biriscv_issue_sched: in-order dual-issue scheduler with hazard, pairing and
// CSR serialisation rules. BIRISCV_ISSUE_STATS_EN adds issue statistic counters.
module biriscv_issue_sched
  import biriscv_issue_pkg::*;
#(
  parameter int DUAL_ISSUE         = 1,
  parameter int POST_SERIAL_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        slot0_valid_i,
  input  logic [31:0] slot0_instr_i,
  input  logic [31:0] slot0_pc_i,
  input  logic [7:0]  slot0_class_i,
  input  logic        slot1_valid_i,
  input  logic [31:0] slot1_instr_i,
  input  logic [31:0] slot1_pc_i,
  input  logic [7:0]  slot1_class_i,
  output logic        slot0_accept_o,
  output logic        slot1_accept_o,
  input  logic        stall_i,
  input  logic        branch_request_i,
  input  logic        pipe_idle_i,
  input  logic        wb_load_valid_i,
  input  logic [4:0]  wb_load_rd_i,
  input  logic        div_complete_i,
  output logic        issue0_valid_o,
  output logic [31:0] issue0_instr_o,
  output logic [31:0] issue0_pc_o,
  output logic        issue1_valid_o,
  output logic [31:0] issue1_instr_o,
  output logic [31:0] issue1_pc_o
`ifdef BIRISCV_ISSUE_STATS_EN
  ,
  output logic [31:0] stat_dual_o,
  output logic [31:0] stat_single_o,
  output logic [31:0] stat_stall_o
`endif
);

  logic [STATE_W-1:0] state, state_next;
  logic [2:0]         post_cnt, post_cnt_next;
  logic               accept0, accept1;
  logic               hazard0, hazard1, sb_idle;

  logic [4:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
  assign rd0   = slot0_instr_i[RD_LSB +: 5];
  assign rs1_0 = slot0_instr_i[RS1_LSB +: 5];
  assign rs2_0 = slot0_instr_i[RS2_LSB +: 5];
  assign rd1   = slot1_instr_i[RD_LSB +: 5];
  assign rs1_1 = slot1_instr_i[RS1_LSB +: 5];
  assign rs2_1 = slot1_instr_i[RS2_LSB +: 5];

  logic serial0, serial1, head_serial, issue_en, can_issue, drain_ready, dep, pair_ok;
  logic slot0_ok, slot1_ok;
  logic unused_class;

  assign unused_class = ^{slot0_class_i[CLS_EXEC], slot1_class_i[CLS_EXEC],
                          slot1_class_i[CLS_BRANCH]};

  assign serial0     = slot0_class_i[CLS_CSR] | slot0_class_i[CLS_INVALID];
  assign serial1     = slot1_class_i[CLS_CSR] | slot1_class_i[CLS_INVALID];
  assign head_serial = slot0_valid_i ? serial0 : (slot1_valid_i & serial1);
  assign issue_en    = rst_ni && !branch_request_i && !stall_i;
  assign can_issue   = (state == ST_RUN) || (state == ST_POST);
  assign drain_ready = (state == ST_DRAIN) && pipe_idle_i && sb_idle &&
                       !issue0_valid_o && !issue1_valid_o;

  assign dep = slot0_class_i[CLS_RD_VALID] && (rd0 != 5'd0) &&
               ((rs1_1 == rd0) || (rs2_1 == rd0) ||
                (slot1_class_i[CLS_RD_VALID] && (rd1 == rd0)));

  assign pair_ok = (DUAL_ISSUE != 0) && (state == ST_RUN) && !slot0_class_i[CLS_BRANCH] && !dep &&
                   !(slot0_class_i[CLS_LSU] && slot1_class_i[CLS_LSU]) &&
                   !(slot0_class_i[CLS_MUL] && slot1_class_i[CLS_MUL]) &&
                   !(slot0_class_i[CLS_DIV] && slot1_class_i[CLS_DIV]);

  assign slot0_ok = slot0_valid_i && can_issue && !hazard0 && !serial0;
  assign slot1_ok = slot1_valid_i && can_issue && !hazard1 && !serial1;

  biriscv_issue_scoreboard u_scoreboard (
    .clk           (clk_i),
    .rst_n         (rst_ni),
    .s0_rs1        (rs1_0),
    .s0_rs2        (rs2_0),
    .s0_rd         (rd0),
    .s0_rd_valid   (slot0_class_i[CLS_RD_VALID]),
    .s0_div        (slot0_class_i[CLS_DIV]),
    .s1_rs1        (rs1_1),
    .s1_rs2        (rs2_1),
    .s1_rd         (rd1),
    .s1_rd_valid   (slot1_class_i[CLS_RD_VALID]),
    .s1_div        (slot1_class_i[CLS_DIV]),
    .set0_load     (accept0 & slot0_class_i[CLS_LSU] & slot0_class_i[CLS_RD_VALID]),
    .set0_div      (accept0 & slot0_class_i[CLS_DIV]),
    .set1_load     (accept1 & slot1_class_i[CLS_LSU] & slot1_class_i[CLS_RD_VALID]),
    .set1_div      (accept1 & slot1_class_i[CLS_DIV]),
    .wb_load_valid (wb_load_valid_i),
    .wb_load_rd    (wb_load_rd_i),
    .div_complete  (div_complete_i),
    .hazard0       (hazard0),
    .hazard1       (hazard1),
    .idle          (sb_idle)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ST_RUN;
      post_cnt <= '0;
    end else begin
      state    <= state_next;
      post_cnt <= post_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    post_cnt_next = post_cnt;
    if (branch_request_i) begin
      state_next    = ST_RUN;
      post_cnt_next = '0;
    end else if (!stall_i) begin
      case (state)
        ST_RUN:   if (head_serial) state_next = ST_DRAIN;
        ST_DRAIN: if (drain_ready && (slot0_valid_i || slot1_valid_i)) begin
          state_next    = ST_POST;
          post_cnt_next = 3'(POST_SERIAL_CYCLES);
        end
        ST_POST: begin
          // The counter value names the remaining single-issue cycles, this one included.
          if (post_cnt <= 3'd1) begin
            state_next    = ST_RUN;
            post_cnt_next = '0;
          end else begin
            post_cnt_next = post_cnt - 3'd1;
          end
        end
        default: begin
          state_next    = ST_RUN;
          post_cnt_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    accept0 = 1'b0;
    accept1 = 1'b0;
    if (issue_en) begin
      if (state == ST_DRAIN) begin
        if (drain_ready) begin
          accept0 = slot0_valid_i;
          accept1 = !slot0_valid_i && slot1_valid_i;
        end
      end else begin
        accept0 = slot0_ok;
        accept1 = slot1_ok && (!slot0_valid_i || (slot0_ok && pair_ok));
      end
    end
  end

  assign slot0_accept_o = accept0;
  assign slot1_accept_o = accept1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issue0_valid_o <= 1'b0;
      issue0_instr_o <= '0;
      issue0_pc_o    <= '0;
      issue1_valid_o <= 1'b0;
      issue1_instr_o <= '0;
      issue1_pc_o    <= '0;
    end else if (branch_request_i) begin
      issue0_valid_o <= 1'b0;
      issue1_valid_o <= 1'b0;
    end else if (!stall_i) begin
      issue0_valid_o <= accept0;
      issue0_instr_o <= slot0_instr_i;
      issue0_pc_o    <= slot0_pc_i;
      issue1_valid_o <= accept1;
      issue1_instr_o <= slot1_instr_i;
      issue1_pc_o    <= slot1_pc_i;
    end
  end

`ifdef BIRISCV_ISSUE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_dual_o   <= '0;
      stat_single_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      if (accept0 && accept1) stat_dual_o <= stat_dual_o + 32'd1;
      if (accept0 ^ accept1)  stat_single_o <= stat_single_o + 32'd1;
      if ((slot0_valid_i || slot1_valid_i) && !accept0 && !accept1)
        stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_biriscv_issue_sched.sv
`default_nettype none
// tb_biriscv_issue_sched: table-driven pairing vectors plus directed multi-cycle
// sequences for load/div scoreboard, CSR serialisation, stall and flush.
module tb_biriscv_issue_sched;

  localparam logic [7:0] C_ALU = 8'h41;
  localparam logic [7:0] C_LD  = 8'h21;
  localparam logic [7:0] C_ST  = 8'h20;
  localparam logic [7:0] C_BR  = 8'h10;
  localparam logic [7:0] C_MUL = 8'h09;
  localparam logic [7:0] C_DIV = 8'h05;
  localparam logic [7:0] C_CSR = 8'h03;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        v0, v1, acc0, acc1;
  logic [31:0] i0, i1, pc0, pc1;
  logic [7:0]  c0, c1;
  logic        stall, branch, pipe_idle, wb_v, div_done;
  logic [4:0]  wb_rd;
  logic        iv0, iv1;
  logic [31:0] ii0, ii1, ipc0, ipc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  biriscv_issue_sched #(.DUAL_ISSUE(1), .POST_SERIAL_CYCLES(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .slot0_valid_i(v0), .slot0_instr_i(i0), .slot0_pc_i(pc0), .slot0_class_i(c0),
    .slot1_valid_i(v1), .slot1_instr_i(i1), .slot1_pc_i(pc1), .slot1_class_i(c1),
    .slot0_accept_o(acc0), .slot1_accept_o(acc1),
    .stall_i(stall), .branch_request_i(branch), .pipe_idle_i(pipe_idle),
    .wb_load_valid_i(wb_v), .wb_load_rd_i(wb_rd), .div_complete_i(div_done),
    .issue0_valid_o(iv0), .issue0_instr_o(ii0), .issue0_pc_o(ipc0),
    .issue1_valid_o(iv1), .issue1_instr_o(ii1), .issue1_pc_o(ipc1)
  );

  typedef struct {
    logic v0; logic [31:0] i0; logic [7:0] c0;
    logic v1; logic [31:0] i1; logic [7:0] c1;
    logic e0; logic e1;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] rt(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_v0, input logic [31:0] a_i0, input logic [7:0] a_c0,
                       input logic a_v1, input logic [31:0] a_i1, input logic [7:0] a_c1);
    v0 = a_v0; i0 = a_i0; c0 = a_c0;
    v1 = a_v1; i1 = a_i1; c1 = a_c1;
  endtask

  task automatic cyc(input string nm, input logic e0, input logic e1);
    #2;
    chk({nm, ".acc0"}, 32'(acc0), 32'(e0));
    chk({nm, ".acc1"}, 32'(acc1), 32'(e1));
    step();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    stall = 0; branch = 0; pipe_idle = 1; wb_v = 0; wb_rd = 0; div_done = 0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1, rt(1, 2, 3),   C_ALU, 1, rt(4, 5, 6),  C_ALU, 1, 1};
    vecs[1]  = '{1, rt(5, 1, 2),   C_ALU, 1, rt(6, 5, 3),  C_ALU, 1, 0};
    vecs[2]  = '{1, rt(5, 1, 2),   C_ALU, 1, rt(6, 3, 5),  C_ALU, 1, 0};
    vecs[3]  = '{1, rt(9, 1, 2),   C_ALU, 1, rt(9, 3, 4),  C_ALU, 1, 0};
    vecs[4]  = '{1, rt(0, 1, 2),   C_ALU, 1, rt(3, 0, 0),  C_ALU, 1, 1};
    vecs[5]  = '{1, rt(0, 1, 2),   C_BR,  1, rt(3, 4, 5),  C_ALU, 1, 0};
    vecs[6]  = '{1, rt(10, 1, 0),  C_LD,  1, rt(0, 2, 3),  C_ST,  1, 0};
    vecs[7]  = '{1, rt(12, 1, 2),  C_MUL, 1, rt(13, 3, 4), C_MUL, 1, 0};
    vecs[8]  = '{1, rt(14, 1, 2),  C_DIV, 1, rt(15, 3, 4), C_DIV, 1, 0};
    vecs[9]  = '{1, rt(1, 2, 3),   C_ALU, 1, rt(4, 0, 0),  C_CSR, 1, 0};
    vecs[10] = '{0, rt(1, 2, 3),   C_ALU, 1, rt(4, 5, 6),  C_ALU, 0, 1};
    vecs[11] = '{1, rt(7, 1, 2),   C_ST,  1, rt(8, 7, 1),  C_ALU, 1, 1};

    // Reset state, with a valid head presented to show accepts stay low.
    do_reset();
    rst_ni = 1'b0;
    drive(1, rt(1, 2, 3), C_ALU, 1, rt(4, 5, 6), C_ALU);
    #2;
    chk("rst.acc0", 32'(acc0), 0);
    chk("rst.acc1", 32'(acc1), 0);
    step();
    chk("rst.iv0", 32'(iv0), 0);
    chk("rst.iv1", 32'(iv1), 0);
    chk("rst.ipc0", ipc0, 0);
    chk("rst.ii1", ii1, 0);

    for (int k = 0; k < 12; k++) begin
      do_reset();
      drive(vecs[k].v0, vecs[k].i0, vecs[k].c0, vecs[k].v1, vecs[k].i1, vecs[k].c1);
      pc0 = 32'h1000 + 32'(k) * 8;
      pc1 = pc0 + 4;
      cyc($sformatf("vec%0d", k), vecs[k].e0, vecs[k].e1);
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("vec%0d.iv0", k), 32'(iv0), 32'(vecs[k].e0));
      chk($sformatf("vec%0d.iv1", k), 32'(iv1), 32'(vecs[k].e1));
      if (vecs[k].e0) chk($sformatf("vec%0d.ipc0", k), ipc0, 32'h1000 + 32'(k) * 8);
      if (vecs[k].e1) chk($sformatf("vec%0d.ii1", k), ii1, vecs[k].i1);
    end

    // RAW pair: sub follows add on pipe1 one cycle later.
    do_reset();
    pc0 = 32'h200; pc1 = 32'h204;
    drive(1, rt(5, 1, 2), C_ALU, 1, rt(6, 5, 3), C_ALU);
    cyc("raw.c0", 1, 0);
    v0 = 0;
    chk("raw.iv0", 32'(iv0), 1);
    chk("raw.ipc0", ipc0, 32'h200);
    cyc("raw.c1", 0, 1);
    v1 = 0;
    chk("raw.iv1", 32'(iv1), 1);
    chk("raw.ii1", ii1, rt(6, 5, 3));
    chk("raw.iv0b", 32'(iv0), 0);

    // Load-use: blocked until writeback, set wins over clear.
    do_reset();
    drive(1, rt(7, 1, 0), C_LD, 0, 0, 0);
    cyc("ld.issue", 1, 0);
    drive(1, rt(8, 7, 2), C_ALU, 0, 0, 0);
    cyc("ld.blk0", 0, 0);
    cyc("ld.blk1", 0, 0);
    wb_v = 1; wb_rd = 7;
    cyc("ld.wb", 1, 0);
    wb_v = 0;
    drive(1, rt(7, 1, 0), C_LD, 0, 0, 0);
    cyc("ld.again", 1, 0);
    wb_v = 1; wb_rd = 7;
    cyc("ld.setclr", 1, 0);
    wb_v = 0;
    drive(1, rt(8, 7, 2), C_ALU, 0, 0, 0);
    cyc("ld.pending", 0, 0);
    wb_v = 1; wb_rd = 0;
    cyc("ld.wbx0", 0, 0);
    wb_v = 0;

    // CSR serialisation and the post-serial single-issue window.
    do_reset();
    pipe_idle = 0;
    pc0 = 32'h300; pc1 = 32'h304;
    drive(1, rt(3, 0, 0), C_CSR, 1, rt(4, 1, 2), C_ALU);
    cyc("csr.run", 0, 0);
    cyc("csr.wait0", 0, 0);
    cyc("csr.wait1", 0, 0);
    pipe_idle = 1;
    cyc("csr.drain", 1, 0);
    chk("csr.iv0", 32'(iv0), 1);
    chk("csr.ii0", ii0, rt(3, 0, 0));
    chk("csr.iv1", 32'(iv1), 0);
    drive(1, rt(10, 1, 2), C_ALU, 1, rt(11, 1, 2), C_ALU);
    cyc("csr.post1", 1, 0);
    cyc("csr.post2", 1, 0);
    cyc("csr.resume", 1, 1);

    // Stall holds issue registers; flush beats stall.
    do_reset();
    pc0 = 32'h400; pc1 = 32'h404;
    drive(1, rt(1, 2, 3), C_ALU, 1, rt(4, 5, 6), C_ALU);
    cyc("st.pair", 1, 1);
    pc0 = 32'h410; pc1 = 32'h414;
    stall = 1;
    cyc("st.stall", 0, 0);
    chk("st.hold.iv0", 32'(iv0), 1);
    chk("st.hold.ipc0", ipc0, 32'h400);
    chk("st.hold.ipc1", ipc1, 32'h404);
    branch = 1;
    cyc("st.flush", 0, 0);
    chk("st.flush.iv0", 32'(iv0), 0);
    chk("st.flush.iv1", 32'(iv1), 0);
    stall = 0; branch = 0;

    // Flush during DRAIN keeps the pending load bit and returns to RUN.
    drive(1, rt(7, 1, 0), C_LD, 0, 0, 0);
    cyc("fd.ld", 1, 0);
    pipe_idle = 0;
    drive(1, rt(3, 0, 0), C_CSR, 0, 0, 0);
    cyc("fd.run", 0, 0);
    cyc("fd.drain", 0, 0);
    branch = 1; stall = 1;
    cyc("fd.flush", 0, 0);
    chk("fd.iv0", 32'(iv0), 0);
    chk("fd.iv1", 32'(iv1), 0);
    branch = 0; stall = 0; pipe_idle = 1;
    drive(1, rt(1, 2, 3), C_ALU, 1, rt(4, 5, 6), C_ALU);
    cyc("fd.dual", 1, 1);
    drive(1, rt(8, 7, 2), C_ALU, 0, 0, 0);
    cyc("fd.pend", 0, 0);

    // Divider busy, completion bypass, reset mid-divide.
    do_reset();
    drive(1, rt(11, 1, 2), C_DIV, 0, 0, 0);
    cyc("dv.first", 1, 0);
    drive(1, rt(12, 3, 4), C_DIV, 0, 0, 0);
    cyc("dv.blk0", 0, 0);
    cyc("dv.blk1", 0, 0);
    div_done = 1;
    cyc("dv.done", 1, 0);
    div_done = 0;
    drive(1, rt(13, 12, 1), C_ALU, 0, 0, 0);
    cyc("dv.use", 0, 0);
    rst_ni = 0;
    cyc("dv.rst", 0, 0);
    chk("dv.rst.iv0", 32'(iv0), 0);
    rst_ni = 1;
    cyc("dv.after", 1, 0);
    drive(1, rt(14, 1, 2), C_DIV, 0, 0, 0);
    cyc("dv.newdiv", 1, 0);
    drive(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
